// File: rtl/spi_paint_tx_pkg.sv
// Shared types for the paint-command SPI link: packet layout, colour code, FSM states.
package paint_pkg;

  localparam int PKT_BITS = 24;

  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] rsvd;
    logic       brush;
    color_t     color;
  } paint_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } tx_state_t;

  // Assemble a packet; reserved bits are always driven 0.
  function automatic paint_pkt_t pack_pkt(input logic [7:0] x, input logic [7:0] y,
                                          input logic brush, input color_t color);
    paint_pkt_t p;
    p.x     = x;
    p.y     = y;
    p.rsvd  = 4'b0000;
    p.brush = brush;
    p.color = color;
    return p;
  endfunction

endpackage

// File: rtl/spi_paint_tx_if.sv
// Request handshake plus SPI wire bundle of the paint transmitter.
interface spi_paint_tx_if;
  logic                 valid;
  logic                 ready;
  logic [7:0]           x;
  logic [7:0]           y;
  logic                 brush;
  paint_pkg::color_t    color;
  logic                 sck;
  logic                 sdi;
  logic                 cs;
  logic                 busy;
  logic                 done;

  modport master (output valid, x, y, brush, color,
                  input  ready, sck, sdi, cs, busy, done);

  modport slave  (input  valid, x, y, brush, color,
                  output ready, sck, sdi, cs, busy, done);
endinterface

// File: rtl/spi_paint_tx_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, cleared when idle.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..CLK_DIV-1 and wrap; hold at zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/spi_paint_tx.sv
// SPI mode-0 initiator for 24-bit paint packets; FSM and shift register.
//
//   state | meaning
//   IDLE  | ready=1, waiting for valid
//   SETUP | cs=1, sdi=bit23, sck low for H cycles
//   HIGH  | sck high for H cycles, receiver samples on entry
//   LOW   | sck low, next bit on sdi, H cycles
//   HOLD  | sck low after last bit, cs still high for H cycles
//   GAP   | cs low for GAP_CYCLES cycles, done pulses on first cycle
module spi_paint_tx
  import paint_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset,
  spi_paint_tx_if.slave  bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    BIT_TOP  = 5'(PKT_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [PKT_BITS-1:0]   shift_q, shift_d;
  logic [4:0]            bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  tick;
  logic                  tick_en;
  paint_pkt_t            pkt;

  assign pkt     = pack_pkt(bus.x, bus.y, bus.brush, bus.color);
  assign tick_en = (state_q != ST_IDLE) && (state_q != ST_GAP);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  // Next-state and registered-output decode; sdi is the shift register MSB.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          state_d = ST_SETUP;
          shift_d = pkt;
          bit_d   = BIT_TOP;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (tick) begin
          state_d = ST_HIGH;
          sck_d   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_q == 5'd0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            shift_d = {shift_q[PKT_BITS-2:0], 1'b0};
            bit_d   = bit_q - 5'd1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          cs_d    = 1'b0;
          shift_d = '0;
          done_d  = 1'b1;
          gap_d   = GAP_LAST;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b0;
      sck_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.cs    = cs_q;
  assign bus.sck   = sck_q;
  assign bus.sdi   = shift_q[PKT_BITS-1];
endmodule

// File: tb/tb_spi_paint_tx.sv
// Directed bench for spi_paint_tx: one H=4 instance and one H=1 instance.
module tb_spi_paint_tx;
  import paint_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_paint_tx_if if4 ();
  spi_paint_tx_if if1 ();

  spi_paint_tx #(.CLK_DIV(4), .GAP_CYCLES(8)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  spi_paint_tx #(.CLK_DIV(1), .GAP_CYCLES(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #20 clk = ~clk;

  // Wire monitor for the H=4 instance.
  logic        cs4_p = 0, sck4_p = 0, sdi4_p = 0;
  int          cs_hi4 = 0, gap4 = 0, last_cs_hi4 = 0, last_gap4 = 0;
  int          nbits4 = 0, last_nbits4 = 0, frames4 = 0, done_cnt4 = 0, viol4 = 0;
  int          cyc4 = 0, last_rise4 = 0, last_per4 = 0;
  logic [23:0] cap4 = '0, last_word4 = '0;

  always @(negedge clk) begin
    cyc4++;
    if (reset) begin
      if (if4.cs) begin
        if (!cs4_p) begin cs_hi4 = 1; nbits4 = 0; if (frames4 > 0) last_gap4 = gap4; end
        else cs_hi4++;
      end else begin
        if (cs4_p) begin
          last_cs_hi4 = cs_hi4; last_word4 = cap4; last_nbits4 = nbits4; frames4++; gap4 = 1;
        end else gap4++;
      end
      if (if4.sck && !sck4_p) begin
        cap4 = {cap4[22:0], if4.sdi}; nbits4++;
        last_per4 = cyc4 - last_rise4; last_rise4 = cyc4;
      end
      if (if4.done) begin done_cnt4++; if (!(cs4_p && !if4.cs)) viol4++; end
      if ((if4.ready || if4.done) && if4.cs) viol4++;
      if ((if4.sdi !== sdi4_p) && if4.sck) viol4++;
      if (if4.sck && !if4.cs) viol4++;
    end
    cs4_p = if4.cs; sck4_p = if4.sck; sdi4_p = if4.sdi;
  end

  // Wire monitor for the H=1 instance.
  logic        cs1_p = 0, sck1_p = 0, sdi1_p = 0;
  int          cs_hi1 = 0, last_cs_hi1 = 0, frames1 = 0, done_cnt1 = 0, viol1 = 0;
  int          cyc1 = 0, last_rise1 = 0, last_per1 = 0;
  logic [23:0] cap1 = '0, last_word1 = '0;

  always @(negedge clk) begin
    cyc1++;
    if (reset) begin
      if (if1.cs) begin
        if (!cs1_p) cs_hi1 = 1; else cs_hi1++;
      end else if (cs1_p) begin
        last_cs_hi1 = cs_hi1; last_word1 = cap1; frames1++;
      end
      if (if1.sck && !sck1_p) begin
        cap1 = {cap1[22:0], if1.sdi};
        last_per1 = cyc1 - last_rise1; last_rise1 = cyc1;
      end
      if (if1.done) done_cnt1++;
      if ((if1.ready || if1.done) && if1.cs) viol1++;
      if ((if1.sdi !== sdi1_p) && if1.sck) viol1++;
    end
    cs1_p = if1.cs; sck1_p = if1.sck; sdi1_p = if1.sdi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready4(input string tag);
    int n = 0;
    while (!if4.ready && n < 4000) begin step(); n++; end
    check(tag, if4.ready, 1'b1);
  endtask

  task automatic wait_cs4_high(input string tag);
    int n = 0;
    while (!if4.cs && n < 4000) begin step(); n++; end
    check(tag, if4.cs, 1'b1);
  endtask

  task automatic wait_frames4(input int tgt, input string tag);
    int n = 0;
    while (frames4 < tgt && n < 4000) begin step(); n++; end
    check(tag, 32'(frames4 >= tgt), 32'd1);
  endtask

  task automatic wait_bits4(input int tgt, input string tag);
    int n = 0;
    while (nbits4 < tgt && n < 4000) begin step(); n++; end
    check(tag, 32'(nbits4), 32'(tgt));
  endtask

  // Single accepted request on the H=4 instance, checking the one-cycle latency.
  task automatic send4(input logic [7:0] x, input logic [7:0] y, input logic b,
                       input logic [2:0] c, input string tag);
    wait_ready4({tag, "_idle"});
    if4.x = x; if4.y = y; if4.brush = b; if4.color = c; if4.valid = 1'b1;
    step();
    check({tag, "_cs_latency"}, if4.cs, 1'b1);
    check({tag, "_ready_low"}, if4.ready, 1'b0);
    if4.valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, d0, n;
    if4.valid = 0; if4.x = 0; if4.y = 0; if4.brush = 0; if4.color = 0;
    if1.valid = 0; if1.x = 0; if1.y = 0; if1.brush = 0; if1.color = 0;
    #5 reset = 1'b0;
    repeat (3) step();
    check("rst_ready", if4.ready, 1'b1);
    check("rst_busy",  if4.busy,  1'b0);
    check("rst_cs",    if4.cs,    1'b0);
    check("rst_sck",   if4.sck,   1'b0);
    check("rst_sdi",   if4.sdi,   1'b0);
    check("rst_done",  if4.done,  1'b0);
    check("rst_ready1", if1.ready, 1'b1);
    reset = 1'b1;
    step();

    // 1: basic frame, H=4
    f = frames4; d0 = done_cnt4;
    send4(8'h12, 8'h34, 1'b1, 3'b010, "t1");
    check("t1_busy", if4.busy, 1'b1);
    wait_frames4(f + 1, "t1_end");
    check("t1_word",  32'(last_word4), 32'h12340A);
    check("t1_nbits", 32'(last_nbits4), 32'd24);
    check("t1_cs_hi", 32'(last_cs_hi4), 32'd196);
    check("t1_sck_period", 32'(last_per4), 32'd8);
    check("t1_done_now", if4.done, 1'b1);
    check("t1_gap_busy", if4.busy, 1'b1);
    step();
    check("t1_done_pulse", if4.done, 1'b0);
    repeat (6) step();
    check("t1_gap_last_ready", if4.ready, 1'b0);
    step();
    check("t1_ready_back", if4.ready, 1'b1);
    check("t1_busy_clear", if4.busy, 1'b0);
    check("t1_done_count", 32'(done_cnt4 - d0), 32'd1);

    // 2: field decode of an all-ones / all-zeros packet
    f = frames4; d0 = done_cnt4;
    send4(8'hFF, 8'h00, 1'b0, 3'b111, "t2");
    wait_frames4(f + 1, "t2_end");
    check("t2_x",     32'(last_word4[23:16]), 32'hFF);
    check("t2_y",     32'(last_word4[15:8]),  32'h00);
    check("t2_rsvd",  32'(last_word4[7:4]),   32'h0);
    check("t2_brush", 32'(last_word4[3]),     32'h0);
    check("t2_color", 32'(last_word4[2:0]),   32'h7);
    check("t2_done_count", 32'(done_cnt4 - d0), 32'd1);

    // 3: request during a frame is not taken until after the gap
    f = frames4;
    send4(8'hA5, 8'h5A, 1'b1, 3'b101, "t3");
    wait_bits4(14, "t3_bit10");
    if4.x = 8'h3C; if4.y = 8'hC3; if4.brush = 1'b0; if4.color = 3'b001; if4.valid = 1'b1;
    step();
    check("t3_ready_busy", if4.ready, 1'b0);
    wait_frames4(f + 1, "t3_endA");
    check("t3_wordA", 32'(last_word4), 32'hA55A0D);
    check("t3_nbitsA", 32'(last_nbits4), 32'd24);
    wait_cs4_high("t3_startB");
    if4.valid = 1'b0;
    check("t3_gapAB", 32'(last_gap4), 32'd9);
    wait_frames4(f + 2, "t3_endB");
    check("t3_wordB", 32'(last_word4), 32'h3CC301);

    // 4: back-to-back with valid held high
    wait_ready4("t4_idle");
    f = frames4;
    if4.x = 8'h01; if4.y = 8'h02; if4.brush = 1'b1; if4.color = 3'b000; if4.valid = 1'b1;
    wait_cs4_high("t4_start1");
    if4.x = 8'h80; if4.y = 8'h40; if4.brush = 1'b0; if4.color = 3'b110;
    wait_frames4(f + 1, "t4_end1");
    check("t4_word1", 32'(last_word4), 32'h010208);
    wait_cs4_high("t4_start2");
    if4.valid = 1'b0;
    check("t4_gap", 32'(last_gap4), 32'd9);
    wait_frames4(f + 2, "t4_end2");
    check("t4_word2", 32'(last_word4), 32'h804006);
    check("t4_cs_hi2", 32'(last_cs_hi4), 32'd196);

    // 5: asynchronous reset mid-frame
    f = frames4; d0 = done_cnt4;
    send4(8'h12, 8'h34, 1'b1, 3'b010, "t5");
    wait_bits4(10, "t5_bit10");
    #6 reset = 1'b0;
    #1;
    check("t5_cs_async",    if4.cs,    1'b0);
    check("t5_sck_async",   if4.sck,   1'b0);
    check("t5_sdi_async",   if4.sdi,   1'b0);
    check("t5_ready_async", if4.ready, 1'b1);
    check("t5_busy_async",  if4.busy,  1'b0);
    repeat (3) step();
    reset = 1'b1;
    repeat (20) step();
    check("t5_ready_after", if4.ready, 1'b1);
    check("t5_cs_after",    if4.cs,    1'b0);
    check("t5_no_done",     32'(done_cnt4 - d0), 32'd0);
    check("t5_no_frame",    32'(frames4 - f), 32'd0);
    send4(8'h12, 8'h34, 1'b1, 3'b010, "t5r");
    wait_frames4(f + 1, "t5r_end");
    check("t5r_word", 32'(last_word4), 32'h12340A);

    // 6: H=1 instance
    f = frames1; d0 = done_cnt1;
    if1.x = 8'h12; if1.y = 8'h34; if1.brush = 1'b1; if1.color = 3'b010; if1.valid = 1'b1;
    step();
    check("t6_cs_latency", if1.cs, 1'b1);
    if1.valid = 1'b0;
    n = 0;
    while (frames1 == f && n < 1000) begin step(); n++; end
    check("t6_end", 32'(frames1 - f), 32'd1);
    check("t6_word",  32'(last_word1), 32'h12340A);
    check("t6_cs_hi", 32'(last_cs_hi1), 32'd49);
    check("t6_sck_period", 32'(last_per1), 32'd2);
    check("t6_done_count", 32'(done_cnt1 - d0), 32'd1);

    check("proto_h4", 32'(viol4), 32'd0);
    check("proto_h1", 32'(viol1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
